// File: rtl/svi_array_writer_if.sv
// svi_array_writer_if: one output element (members x, y) of the committed frame array.
interface I;
   logic x;
   logic y;
   modport master (output x, y);
   modport slave  (input  x, y);
endinterface

// File: rtl/svi_array_writer.sv
// svi_array_writer: fills a shadow frame beat by beat, then commits it atomically to u_I.
// Optional o_frame_cnt enabled by SVI_ARRAY_WRITER_FRAME_CNT_EN.
module svi_array_writer #(
   parameter int SIZE = 8
) (
   input  logic i_clk,
   input  logic i_arst_n,
   input  logic i_valid,
   output logic o_ready,
   input  logic i_a,
   input  logic i_b,
   input  logic i_flush,
   I.master     u_I [SIZE-1:0],
   output logic o_frame_done
`ifdef SVI_ARRAY_WRITER_FRAME_CNT_EN
   ,
   output logic [7:0] o_frame_cnt
`endif
);
   localparam int PW = $clog2(SIZE);
   typedef enum logic {FILL, COMMIT} state_t;
   state_t          r_state, w_next;
   logic [PW-1:0]   r_ptr, w_ptr_nxt;
   logic [SIZE-1:0] r_sx, r_sy, r_ux, r_uy;
   logic            w_acc, w_last;
   assign o_ready      = (r_state == FILL);
   assign o_frame_done = (r_state == COMMIT);
   assign w_acc        = i_valid & o_ready & ~i_flush;
   assign w_last       = (r_ptr == PW'(SIZE - 1));
   always_comb begin
      w_next    = r_state;
      w_ptr_nxt = r_ptr;
      if (r_state == COMMIT) w_next = FILL;
      else if (i_flush) w_ptr_nxt = '0;
      else if (w_acc) begin
         w_ptr_nxt = w_last ? '0 : r_ptr + 1'b1;
         w_next    = w_last ? COMMIT : FILL;
      end
   end
   always_ff @(posedge i_clk or negedge i_arst_n)
      if (!i_arst_n) begin
         r_state <= FILL;
         r_ptr   <= '0;
         r_sx    <= '0;
         r_sy    <= '0;
         r_ux    <= '0;
         r_uy    <= '0;
      end else begin
         r_state <= w_next;
         r_ptr   <= w_ptr_nxt;
         if (w_acc) begin
            r_sx[r_ptr] <= i_a;
            r_sy[r_ptr] <= i_b;
         end
         // whole frame lands on u_I in one edge so partial frames are never visible
         if (r_state == COMMIT) begin
            r_ux <= r_sx;
            r_uy <= r_sy;
         end
      end
   for (genvar g = 0; g < SIZE; g++) begin : g_out
      assign u_I[g].x = r_ux[g];
      assign u_I[g].y = r_uy[g];
   end
`ifdef SVI_ARRAY_WRITER_FRAME_CNT_EN
   logic [7:0] r_frame_cnt;
   always_ff @(posedge i_clk or negedge i_arst_n)
      if (!i_arst_n) r_frame_cnt <= '0;
      else if (r_state == COMMIT) r_frame_cnt <= r_frame_cnt + 8'd1;
   assign o_frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_svi_array_writer.sv
// tb_svi_array_writer: directed self-checking bench for svi_array_writer (SIZE=8).
module tb_svi_array_writer;
   logic       i_clk = 1'b0;
   logic       i_arst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic       i_a = 1'b0;
   logic       i_b = 1'b0;
   logic       i_flush = 1'b0;
   logic       o_ready;
   logic       o_frame_done;
   logic [7:0] w_x, w_y;
   int         checks = 0;
   int         failures = 0;
   int         done_cnt = 0;
   int         base;
`ifdef SVI_ARRAY_WRITER_FRAME_CNT_EN
   logic [7:0] o_frame_cnt;
`endif
   I u_I [7:0] ();
   svi_array_writer #(.SIZE(8)) dut (
      .i_clk(i_clk),
      .i_arst_n(i_arst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_a(i_a),
      .i_b(i_b),
      .i_flush(i_flush),
      .u_I(u_I),
      .o_frame_done(o_frame_done)
`ifdef SVI_ARRAY_WRITER_FRAME_CNT_EN
      ,
      .o_frame_cnt(o_frame_cnt)
`endif
   );
   for (genvar g = 0; g < 8; g++) begin : g_tap
      assign w_x[g] = u_I[g].x;
      assign w_y[g] = u_I[g].y;
   end
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) if (o_frame_done === 1'b1) done_cnt++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask
   task automatic beat(input logic a, input logic b);
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      step();
   endtask
   initial begin
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_done", 32'(o_frame_done), 32'd0);
      chk("rst_u", {16'd0, w_x, w_y}, 32'h0000);
      i_arst_n = 1'b1;
      // frame of alternating x/y
      base = done_cnt;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) chk("t1_ready_fill", 32'(o_ready), 32'd1);
         beat(k[0], ~k[0]);
      end
      i_valid = 1'b0;
      chk("t1_ready_commit", 32'(o_ready), 32'd0);
      chk("t1_done_commit", 32'(o_frame_done), 32'd1);
      chk("t1_u_pre", {16'd0, w_x, w_y}, 32'h0000);
      step();
      chk("t1_ready_after", 32'(o_ready), 32'd1);
      chk("t1_u_post", {16'd0, w_x, w_y}, 32'hAA55);
      chk("t1_done_cnt", 32'(done_cnt - base), 32'd1);
      // partial frame then flush, with a beat offered during the flush
      base = done_cnt;
      for (int k = 0; k < 5; k++) beat(1'b0, 1'b0);
      i_flush = 1'b1;
      beat(1'b0, 1'b0);
      i_flush = 1'b0;
      for (int k = 0; k < 8; k++) beat(1'b1, 1'b1);
      i_valid = 1'b0;
      chk("t2_done_commit", 32'(o_frame_done), 32'd1);
      chk("t2_u_pre", {16'd0, w_x, w_y}, 32'hAA55);
      step();
      chk("t2_u_post", {16'd0, w_x, w_y}, 32'hFFFF);
      chk("t2_done_cnt", 32'(done_cnt - base), 32'd1);
      // valid toggling: 8th accepted beat lands on cycle 14
      base = done_cnt;
      for (int i = 0; i < 16; i++) begin
         if (i == 14) chk("t3_u_hold", {16'd0, w_x, w_y}, 32'hFFFF);
         if (i == 14) chk("t3_no_done", 32'(done_cnt - base), 32'd0);
         if (i == 15) chk("t3_done_commit", 32'(o_frame_done), 32'd1);
         i_valid = (i % 2 == 0);
         i_a     = 1'b1;
         i_b     = 1'b0;
         step();
      end
      i_valid = 1'b0;
      chk("t3_u_post", {16'd0, w_x, w_y}, 32'hFF00);
      chk("t3_done_cnt", 32'(done_cnt - base), 32'd1);
      // reset mid-frame at wr_ptr=6 after an all-ones commit
      for (int k = 0; k < 8; k++) beat(1'b1, 1'b1);
      i_valid = 1'b0;
      step();
      chk("t4_u_ones", {16'd0, w_x, w_y}, 32'hFFFF);
      for (int k = 0; k < 6; k++) beat(1'b0, 1'b0);
      i_valid = 1'b0;
      i_arst_n = 1'b0;
      #1;
      chk("t4_u_rst", {16'd0, w_x, w_y}, 32'h0000);
      chk("t4_ready_rst", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_arst_n = 1'b1;
      base = done_cnt;
      for (int k = 0; k < 8; k++) beat(1'b1, 1'b0);
      i_valid = 1'b0;
      chk("t4_done_commit", 32'(o_frame_done), 32'd1);
      chk("t4_u_pre", {16'd0, w_x, w_y}, 32'h0000);
      step();
      chk("t4_u_post", {16'd0, w_x, w_y}, 32'hFF00);
      chk("t4_done_cnt", 32'(done_cnt - base), 32'd1);
`ifdef SVI_ARRAY_WRITER_FRAME_CNT_EN
      i_arst_n = 1'b0;
      @(negedge i_clk);
      i_arst_n = 1'b1;
      chk("t5_cnt_rst", 32'(o_frame_cnt), 32'd0);
      base    = done_cnt;
      i_valid = 1'b1;
      i_a     = 1'b1;
      i_b     = 1'b1;
      repeat (257 * 9) step();
      i_valid = 1'b0;
      chk("t5_cnt", 32'(o_frame_cnt), 32'd1);
      chk("t5_frames", 32'(done_cnt - base), 32'd257);
      chk("t5_phase", 32'({o_ready, o_frame_done}), 32'b10);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
